// File: rtl/async_fifo_pkg.sv
// Shared helpers for the asynchronous FIFO: Gray/binary pointer conversion
// and the depth of the clock-domain-crossing synchronizer.
package async_fifo_pkg;

   localparam int SYNC_STAGES = 2;
   localparam int GRAY_FN_W   = 32;

   // Callers zero-extend narrower pointers in and size-cast the result back.
   function automatic logic [GRAY_FN_W-1:0] bin2gray(input logic [GRAY_FN_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [GRAY_FN_W-1:0] gray2bin(input logic [GRAY_FN_W-1:0] g);
      logic [GRAY_FN_W-1:0] b;
      b[GRAY_FN_W-1] = g[GRAY_FN_W-1];
      for (int i = GRAY_FN_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/async_fifo_read_ctrl_gray_sync2.sv
// gray_sync2: flop chain that brings a Gray-coded pointer into the local clock
// domain; every stage clears to zero on the asynchronous active-high reset.
module gray_sync2
   import async_fifo_pkg::*;
#(
   parameter int WIDTH = 6
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_stage [SYNC_STAGES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/async_fifo_read_ctrl.sv
// Read side of an asynchronous FIFO: synchronized write pointer, empty flag,
// and a 2-entry output buffer. `ASYNC_FIFO_READ_LEVEL_EN adds p_read_level.
module async_fifo_read_ctrl
   import async_fifo_pkg::*;
#(
   parameter int SIZE_LOG2  = 5,
   parameter int DATA_WIDTH = 8
)
(
   input  logic                  read_clk,
   input  logic                  read_rst,
   input  logic [SIZE_LOG2:0]    p_write_ptr_gray,
   input  logic [DATA_WIDTH-1:0] p_mem_data,
   output logic [SIZE_LOG2-1:0]  p_read_addr,
   output logic [SIZE_LOG2:0]    p_read_ptr_gray,
   output logic                  p_read_empty,
   output logic                  p_out_valid,
   input  logic                  p_out_ready,
   output logic [DATA_WIDTH-1:0] p_out_data
`ifdef ASYNC_FIFO_READ_LEVEL_EN
   ,
   output logic [SIZE_LOG2:0]    p_read_level
`endif
);

   localparam int PTR_W = SIZE_LOG2 + 1;

   logic [PTR_W-1:0]      r_write_ptr_gray_sync2;
   logic [PTR_W-1:0]      r_read_ptr_bin;
   logic [PTR_W-1:0]      r_read_ptr_gray;
   logic [PTR_W-1:0]      w_read_ptr_bin_next;
   logic [PTR_W-1:0]      w_read_ptr_gray_next;
   logic [1:0]            r_buf_count;
   logic [DATA_WIDTH-1:0] r_buf_head;
   logic [DATA_WIDTH-1:0] r_buf_tail;
   logic                  r_read_empty;
   logic                  w_xfer;
   logic                  w_fetch;
   logic                  w_fill_tail;

   gray_sync2 #(
      .WIDTH (PTR_W)
   ) u_write_ptr_sync (
      .clk (read_clk),
      .rst (read_rst),
      .d   (p_write_ptr_gray),
      .q   (r_write_ptr_gray_sync2)
   );

   // Stream output: a word moves on any edge where p_out_valid && p_out_ready;
   // until then p_out_valid and p_out_data hold, and valid never depends on ready.
   assign p_out_valid = (r_buf_count != 2'd0);
   assign p_out_data  = r_buf_head;
   assign w_xfer      = p_out_valid && p_out_ready;

   // A fetch may reuse the slot freed by a same-cycle transfer, so a full
   // buffer still streams one word per cycle.
   assign w_fetch = !r_read_empty && ((r_buf_count < 2'd2) || w_xfer);

   assign w_read_ptr_bin_next  = r_read_ptr_bin + {{SIZE_LOG2{1'b0}}, w_fetch};
   assign w_read_ptr_gray_next = PTR_W'(bin2gray(GRAY_FN_W'(w_read_ptr_bin_next)));

   // Slot that receives the fetched word once any outgoing head has shifted out.
   assign w_fill_tail = (r_buf_count == 2'd2) || ((r_buf_count == 2'd1) && !w_xfer);

   always_ff @(posedge read_clk or posedge read_rst) begin
      if (read_rst) begin
         r_read_ptr_bin  <= '0;
         r_read_ptr_gray <= '0;
         r_read_empty    <= 1'b1;
      end else begin
         r_read_ptr_bin  <= w_read_ptr_bin_next;
         r_read_ptr_gray <= w_read_ptr_gray_next;
         r_read_empty    <= (w_read_ptr_gray_next == r_write_ptr_gray_sync2);
      end
   end

   always_ff @(posedge read_clk or posedge read_rst) begin
      if (read_rst) begin
         r_buf_count <= 2'd0;
         r_buf_head  <= '0;
         r_buf_tail  <= '0;
      end else begin
         r_buf_count <= r_buf_count + {1'b0, w_fetch} - {1'b0, w_xfer};
         if (w_xfer) begin
            r_buf_head <= r_buf_tail;
         end
         if (w_fetch) begin
            if (w_fill_tail) begin
               r_buf_tail <= p_mem_data;
            end else begin
               r_buf_head <= p_mem_data;
            end
         end
      end
   end

   assign p_read_addr     = r_read_ptr_bin[SIZE_LOG2-1:0];
   assign p_read_ptr_gray = r_read_ptr_gray;
   assign p_read_empty    = r_read_empty;

`ifdef ASYNC_FIFO_READ_LEVEL_EN
   logic [PTR_W-1:0] w_write_ptr_bin_sync;

   assign w_write_ptr_bin_sync = PTR_W'(gray2bin(GRAY_FN_W'(r_write_ptr_gray_sync2)));

   // Modulo subtraction across the extra pointer bit yields 0..2**SIZE_LOG2.
   always_ff @(posedge read_clk or posedge read_rst) begin
      if (read_rst) begin
         p_read_level <= '0;
      end else begin
         p_read_level <= w_write_ptr_bin_sync - r_read_ptr_bin;
      end
   end
`endif

endmodule

// File: tb/tb_async_fifo_read_ctrl.sv
// Bench for async_fifo_read_ctrl (SIZE_LOG2 = 2): word-count reference model,
// per-cycle output compare, and directed literal checks.
module tb_async_fifo_read_ctrl;

   localparam int SL = 2;
   localparam int DW = 8;
   localparam int PW = SL + 1;

   logic          clk = 1'b0;
   logic          read_rst;
   logic [PW-1:0] p_write_ptr_gray;
   logic [DW-1:0] p_mem_data;
   logic [SL-1:0] p_read_addr;
   logic [PW-1:0] p_read_ptr_gray;
   logic          p_read_empty;
   logic          p_out_valid;
   logic          p_out_ready;
   logic [DW-1:0] p_out_data;
`ifdef ASYNC_FIFO_READ_LEVEL_EN
   logic [PW-1:0] p_read_level;
`endif

   logic [DW-1:0] mem [4];
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] m_q [$];
   logic [DW-1:0] m_word;
   logic [PW-1:0] prev_gray;
   int            wcount;
   int            m_rcount;
   int            m_s1;
   int            m_s2;
   int            m_level;
   int            m_new_r;
   bit            m_empty;
   bit            m_xfer;
   bit            m_fetch;
   bit            wrap_seen;
   int            delivered;
   int            n_vec;
   int            n_err;

   async_fifo_read_ctrl #(
      .SIZE_LOG2  (SL),
      .DATA_WIDTH (DW)
   ) dut (
      .read_clk         (clk),
      .read_rst         (read_rst),
      .p_write_ptr_gray (p_write_ptr_gray),
      .p_mem_data       (p_mem_data),
      .p_read_addr      (p_read_addr),
      .p_read_ptr_gray  (p_read_ptr_gray),
      .p_read_empty     (p_read_empty),
      .p_out_valid      (p_out_valid),
      .p_out_ready      (p_out_ready),
      .p_out_data       (p_out_data)
`ifdef ASYNC_FIFO_READ_LEVEL_EN
      ,
      .p_read_level     (p_read_level)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   assign p_mem_data = mem[p_read_addr];

   function automatic int gray_of(input int b);
      int m;
      m = b & 7;
      return m ^ (m >> 1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks (called just after a falling edge) ----------------
   task automatic write_word(input logic [DW-1:0] d);
      mem[wcount & 3] = d;
      exp_q.push_back(d);
      wcount++;
      p_write_ptr_gray = PW'(gray_of(wcount));
   endtask

   task automatic assert_rst();
      @(negedge clk);
      read_rst = 1'b1;
      wcount = 0;
      p_write_ptr_gray = '0;
      exp_q.delete();
   endtask

   task automatic release_rst();
      repeat (2) @(negedge clk);
      read_rst = 1'b0;
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // ---------------- reference model + per-cycle compare ----------------
   // The reader sees the write count from two edges back; it pulls words while
   // any are visible and fewer than two are held, or one leaves the same cycle.
   always @(posedge clk) begin
      if (read_rst) begin
         m_q.delete();
         m_rcount = 0;
         m_empty  = 1'b1;
         m_s1     = 0;
         m_s2     = 0;
         m_level  = 0;
      end else begin
         m_xfer  = (m_q.size() != 0) && p_out_ready;
         m_fetch = !m_empty && ((m_q.size() < 2) || m_xfer);
         m_new_r = m_rcount + (m_fetch ? 1 : 0);
         m_level = (m_s2 - m_rcount) & 7;
         m_empty = ((m_new_r & 7) == (m_s2 & 7));
         if (m_xfer) begin
            m_word = m_q.pop_front();
            delivered++;
            if (exp_q.size() == 0) begin
               chk("order_underrun", 32'(m_word), 32'hffff_ffff);
            end else begin
               chk("order", 32'(m_word), 32'(exp_q.pop_front()));
            end
         end
         if (m_fetch) begin
            m_q.push_back(mem[m_rcount & 3]);
            m_rcount = m_new_r;
         end
         m_s2 = m_s1;
         m_s1 = wcount;
      end
      #1;
      chk("valid", 32'(p_out_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) chk("data", 32'(p_out_data), 32'(m_q[0]));
      if (read_rst) chk("data_rst", 32'(p_out_data), 32'd0);
      chk("empty", 32'(p_read_empty), 32'(m_empty));
      chk("ptr_gray", 32'(p_read_ptr_gray), 32'(gray_of(m_rcount)));
      chk("addr", 32'(p_read_addr), 32'(m_rcount & 3));
`ifdef ASYNC_FIFO_READ_LEVEL_EN
      chk("level", 32'(p_read_level), 32'(m_level));
`endif
      if (read_rst) begin
         prev_gray = '0;
      end else begin
         chk("gray_step", 32'($countones(prev_gray ^ p_read_ptr_gray) <= 1), 32'd1);
         if (prev_gray == 3'b100 && p_read_ptr_gray == 3'b000) wrap_seen = 1'b1;
         prev_gray = p_read_ptr_gray;
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int sent;
      int cyc;
      n_vec = 0;
      n_err = 0;
      wcount = 0;
      delivered = 0;
      wrap_seen = 1'b0;
      prev_gray = '0;
      read_rst = 1'b1;
      p_out_ready = 1'b0;
      p_write_ptr_gray = '0;
      for (int i = 0; i < 4; i++) mem[i] = '0;

      // Idle after reset: nothing visible, address parked at 0.
      repeat (3) @(negedge clk);
      read_rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         settle();
         chk("idle_addr", 32'(p_read_addr), 32'd0);
      end
      chk("idle_empty", 32'(p_read_empty), 32'd1);
      chk("idle_valid", 32'(p_out_valid), 32'd0);

      // Single word: empty drops after edge 3, valid rises after edge 4.
      assert_rst();
      release_rst();
      p_out_ready = 1'b1;
      @(negedge clk);
      write_word(8'hA5);
      @(posedge clk);
      @(posedge clk);
      settle();
      chk("one_e3_empty", 32'(p_read_empty), 32'd0);
      chk("one_e3_valid", 32'(p_out_valid), 32'd0);
      settle();
      chk("one_e4_valid", 32'(p_out_valid), 32'd1);
      chk("one_e4_data", 32'(p_out_data), 32'hA5);
      chk("one_e4_gray", 32'(p_read_ptr_gray), 32'd1);
      chk("one_e4_empty", 32'(p_read_empty), 32'd1);
      settle();
      chk("one_e5_valid", 32'(p_out_valid), 32'd0);

      // Backpressure: four words, ready low -> only two leave memory.
      assert_rst();
      release_rst();
      p_out_ready = 1'b0;
      @(negedge clk);
      write_word(8'h11);
      write_word(8'h22);
      write_word(8'h33);
      write_word(8'h44);
      repeat (10) @(posedge clk);
      #2;
      chk("bp_gray", 32'(p_read_ptr_gray), 32'd3);
      chk("bp_addr", 32'(p_read_addr), 32'd2);
      chk("bp_valid", 32'(p_out_valid), 32'd1);
      chk("bp_data", 32'(p_out_data), 32'h11);
      chk("bp_empty", 32'(p_read_empty), 32'd0);
      @(negedge clk);
      p_out_ready = 1'b1;
      settle();
      chk("bp_r1_data", 32'(p_out_data), 32'h22);
      settle();
      chk("bp_r2_data", 32'(p_out_data), 32'h33);
      chk("bp_r2_gray", 32'(p_read_ptr_gray), 32'd6);
      chk("bp_r2_empty", 32'(p_read_empty), 32'd1);
      settle();
      chk("bp_r3_data", 32'(p_out_data), 32'h44);
      chk("bp_r3_valid", 32'(p_out_valid), 32'd1);
      settle();
      chk("bp_r4_valid", 32'(p_out_valid), 32'd0);

      // Continuous stream of 20 words through a 4-deep memory (pointer wraps).
      assert_rst();
      release_rst();
      p_out_ready = 1'b1;
      delivered = 0;
      wrap_seen = 1'b0;
      sent = 0;
      cyc = 0;
      while ((sent < 20 || delivered < 20) && cyc < 300) begin
         @(negedge clk);
         if (sent < 20 && (wcount - m_rcount) < 4) begin
            write_word(8'(8'h40 + sent));
            sent++;
         end
         cyc++;
      end
      chk("stream_delivered", 32'(delivered), 32'd20);
      chk("stream_wrap", 32'(wrap_seen), 32'd1);
      repeat (3) settle();
      chk("stream_gray", 32'(p_read_ptr_gray), 32'd6);
      chk("stream_empty", 32'(p_read_empty), 32'd1);

      // Reset with two words buffered, then the first fetch reads address 0.
      assert_rst();
      release_rst();
      p_out_ready = 1'b0;
      @(negedge clk);
      write_word(8'h5A);
      write_word(8'h6B);
      repeat (8) @(posedge clk);
      #2;
      chk("rb_valid", 32'(p_out_valid), 32'd1);
      chk("rb_data", 32'(p_out_data), 32'h5A);
      chk("rb_gray", 32'(p_read_ptr_gray), 32'd3);
      assert_rst();
      #1;
      chk("rst_valid", 32'(p_out_valid), 32'd0);
      chk("rst_gray", 32'(p_read_ptr_gray), 32'd0);
      chk("rst_addr", 32'(p_read_addr), 32'd0);
      chk("rst_empty", 32'(p_read_empty), 32'd1);
      chk("rst_data", 32'(p_out_data), 32'd0);
      release_rst();
      p_out_ready = 1'b1;
      @(negedge clk);
      write_word(8'hC3);
      repeat (4) @(posedge clk);
      #2;
      chk("post_rst_valid", 32'(p_out_valid), 32'd1);
      chk("post_rst_data", 32'(p_out_data), 32'hC3);
      chk("post_rst_gray", 32'(p_read_ptr_gray), 32'd1);

`ifdef ASYNC_FIFO_READ_LEVEL_EN
      // Level: write pointer at 4, nothing read yet, then two fetches.
      assert_rst();
      release_rst();
      p_out_ready = 1'b0;
      @(negedge clk);
      write_word(8'h01);
      write_word(8'h02);
      write_word(8'h03);
      write_word(8'h04);
      @(posedge clk);
      @(posedge clk);
      settle();
      chk("lvl_e3", 32'(p_read_level), 32'd4);
      repeat (8) settle();
      chk("lvl_held", 32'(p_read_level), 32'd2);
      @(negedge clk);
      p_out_ready = 1'b1;
      repeat (8) settle();
      chk("lvl_drained", 32'(p_read_level), 32'd0);
`endif

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/async_fifo_read_ctrl.md
ASYNC_FIFO_READ_CTRL -- requirements
Module: async_fifo_read_ctrl

Interface
REQ-001 SHALL take parameter SIZE_LOG2, default 5: memory depth 2**SIZE_LOG2; pointers SIZE_LOG2+1 bits.
REQ-002 SHALL take parameter DATA_WIDTH, default 8: word width.
REQ-003 SHALL use one clock and one reset; reset is asynchronous and active-high.
REQ-004 read_clk  in  1  sole clock; all state on rising edge.
REQ-005 read_rst  in  1  async active-high reset.
REQ-006 p_write_ptr_gray  in  SIZE_LOG2+1  write-domain Gray pointer, asynchronous to read_clk.
REQ-007 p_mem_data  in  DATA_WIDTH  memory read data, combinational from p_read_addr.
REQ-008 p_read_addr  out  SIZE_LOG2  r_read_ptr_bin[SIZE_LOG2-1:0].
REQ-009 p_read_ptr_gray  out  SIZE_LOG2+1  registered r_read_ptr_gray, to write domain.
REQ-010 p_read_empty  out  1  registered empty flag.
REQ-011 p_out_valid / p_out_ready / p_out_data  out/in/out  1/1/DATA_WIDTH  stream output.

Function
REQ-012 SHALL pass p_write_ptr_gray through two flops: r_write_ptr_gray_sync1, then r_write_ptr_gray_sync2.
REQ-013 SHALL hold r_read_ptr_bin and r_read_ptr_gray; r_read_ptr_gray == bin2gray(r_read_ptr_bin) after every edge.
REQ-014 fetch = !p_read_empty && (buf_count < 2 || (p_out_valid && p_out_ready)).
REQ-015 On fetch, SHALL capture p_mem_data into a 2-entry output buffer and increment r_read_ptr_bin by exactly 1 on the same edge.
REQ-016 w_read_ptr_gray_next = bin2gray(r_read_ptr_bin + fetch); p_read_empty registers (w_read_ptr_gray_next == r_write_ptr_gray_sync2).
REQ-017 Pointer wraps 2**(SIZE_LOG2+1)-1 -> 0 with a single-bit Gray change; no other wrap handling.
REQ-018 r_read_ptr_gray SHALL change by at most one bit per edge.
REQ-019 Buffer is FIFO-ordered; p_out_valid = (buf_count != 0); p_out_data = head entry.
REQ-020 Output handshake: transfer when p_out_valid && p_out_ready; p_out_valid and p_out_data SHALL remain stable until transfer.
REQ-021 Simultaneous fetch and transfer at buf_count == 2 SHALL keep count 2 and sustain one word per cycle.
REQ-022 With p_out_ready held low, at most 2 words leave memory; no further pointer advance.
REQ-023 Latency: a new p_write_ptr_gray value stable before edge 1 -> sync2 at edge 2 -> p_read_empty low after edge 3 -> p_out_valid high after edge 4.

Reset
REQ-024 While read_rst is high: pointers, sync flops, and buffer count SHALL be 0; p_read_empty = 1; p_out_valid = 0; p_out_data = 0.
REQ-025 Reset mid-operation SHALL discard buffered words; first post-reset fetch reads address 0.
REQ-026 No output SHALL be X/Z after read_rst is deasserted.

Configuration
REQ-027 Macro ASYNC_FIFO_READ_LEVEL_EN defined: adds output p_read_level [SIZE_LOG2:0], registered as gray2bin(r_write_ptr_gray_sync2) - r_read_ptr_bin (modulo 2**(SIZE_LOG2+1)). Value is 0 at reset and never exceeds 2**SIZE_LOG2.
REQ-028 Macro undefined: port and logic are absent; all other behaviour is identical.

Structure
REQ-029 Package async_fifo_pkg SHALL hold the bin2gray/gray2bin functions and the constant SYNC_STAGES = 2.
REQ-030 The synchronizer SHALL be sub-module gray_sync2 (parameter WIDTH, two flops, async active-high reset to 0).

Verification
REQ-031 Reset with p_write_ptr_gray = 0 -> p_read_empty = 1, p_out_valid = 0; p_read_addr stays 0 for 20 cycles.
REQ-032 SIZE_LOG2 = 2; p_write_ptr_gray 0 -> 1 (one word, mem[0] = 8'hA5), p_out_ready = 1 -> p_out_valid high after edge 4 with data A5, then p_read_empty = 1 and p_read_ptr_gray = 1.
REQ-033 4 words written, p_out_ready = 0 -> exactly 2 fetches; p_read_ptr_gray = 3; data stable; release ready -> remaining 2 words delivered in order.
REQ-034 Continuous stream of 20 words with ready = 1 -> one word per cycle after fill; pointer wraps 7 -> 0; Gray changes one bit per edge; data in order.
REQ-035 Assert read_rst with 2 words buffered -> p_out_valid drops immediately, pointers = 0, p_read_empty = 1.
REQ-036 ASYNC_FIFO_READ_LEVEL_EN defined, write pointer at binary 4, nothing read -> p_read_level = 4 after sync; decrements by 1 per fetch.
